// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: shift op codes, FSM encoding, default width.
package shift_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response channels of both requesters plus the busy flag.
interface shift_arbiter_if #(parameter int DATA_WIDTH = 32);

    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [1:0]            req0_op;
    logic                  resp0_valid;
    logic                  resp0_ready;
    logic [DATA_WIDTH-1:0] resp0_result;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [1:0]            req1_op;
    logic                  resp1_valid;
    logic                  resp1_ready;
    logic [DATA_WIDTH-1:0] resp1_result;

    logic                  busy;

    modport master (
        output req0_valid, req0_A, req0_B, req0_op, resp0_ready,
        output req1_valid, req1_A, req1_B, req1_op, resp1_ready,
        input  req0_ready, resp0_valid, resp0_result,
        input  req1_ready, resp1_valid, resp1_result,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_op, resp0_ready,
        input  req1_valid, req1_A, req1_B, req1_op, resp1_ready,
        output req0_ready, resp0_valid, resp0_result,
        output req1_ready, resp1_valid, resp1_result,
        output busy
    );

endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter: sll / srl / sra; the reserved op code yields zero.
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int SHW = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [SHW-1:0]        amt,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] a_s;

    assign a_s = signed'(a);

    always_comb begin
        y = '0;
        case (op)
            SH_SLL:  y = a << amt;
            SH_SRL:  y = a >> amt;
            SH_SRA:  y = unsigned'(a_s >>> amt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, with a one-entry response buffer.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREQ       = 2
) (
    input  logic             clk,
    input  logic             rst,
    shift_arbiter_if.slave   bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int SHW = $clog2(DATA_WIDTH);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] res_q;
    logic [IDW-1:0]        owner_q;
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        grant;

    logic                  resp_fire;
    logic                  accept;
    logic                  any_req;
    logic                  req_fire;

    logic [DATA_WIDTH-1:0] sh_a;
    logic [SHW-1:0]        sh_amt;
    logic [1:0]            sh_op;
    logic [DATA_WIDTH-1:0] sh_y;

    // Only the owner's ready drains the buffer; the other ready is ignored.
    assign resp_fire = (state == S_RESP) && (owner_q[0] ? bus.resp1_ready : bus.resp0_ready);

    // Held off during reset so no handshake can complete while the buffer is being discarded.
    assign accept  = !rst && ((state == S_IDLE) || resp_fire);
    assign any_req = bus.req0_valid || bus.req1_valid;

    assign grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant : IDW'(bus.req1_valid);

    assign bus.req0_ready = accept && any_req && (grant == IDW'(0));
    assign bus.req1_ready = accept && any_req && (grant == IDW'(1));
    assign req_fire       = accept && any_req;

    // With no grant the mux defaults to requester 0.
    assign sh_a   = grant[0] ? bus.req1_A : bus.req0_A;
    assign sh_amt = grant[0] ? bus.req1_B[SHW-1:0] : bus.req0_B[SHW-1:0];
    assign sh_op  = grant[0] ? bus.req1_op : bus.req0_op;

    shift_arbiter_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .a   (sh_a),
        .amt (sh_amt),
        .op  (sh_op),
        .y   (sh_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (req_fire)       state_nxt = S_RESP;
        else if (resp_fire) state_nxt = S_IDLE;
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= '0;
            owner_q    <= '0;
            last_grant <= IDW'(1);
        end else if (req_fire) begin
            res_q      <= sh_y;
            owner_q    <= grant;
            last_grant <= grant;
        end
    end

    assign bus.resp0_valid  = (state == S_RESP) && (owner_q == IDW'(0));
    assign bus.resp1_valid  = (state == S_RESP) && (owner_q == IDW'(1));
    assign bus.resp0_result = res_q;
    assign bus.resp1_result = res_q;
    assign bus.busy         = (state == S_RESP);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter against a transaction-level reference model.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_arbiter_if #(.DATA_WIDTH(32)) bus_if ();

    shift_arbiter #(.DATA_WIDTH(32), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered result, its owner, and the last winner.
    logic        m_full;
    logic        m_owner;
    logic        m_last;
    logic [31:0] m_res;
    logic        acc0, acc1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int          n;
        logic [31:0] r;
        n = int'(b % 32);
        r = 32'h0;
        case (op)
            2'b00: r = a << n;
            2'b10: r = a >> n;
            2'b11: begin
                r = a >> n;
                if (a[31]) for (int i = 0; i < n; i++) r[31-i] = 1'b1;
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_res   = 32'h0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (n == 0) begin
            bus_if.req0_valid = v; bus_if.req0_A = a; bus_if.req0_B = b; bus_if.req0_op = op;
        end else begin
            bus_if.req1_valid = v; bus_if.req1_A = a; bus_if.req1_B = b; bus_if.req1_op = op;
        end
    endtask

    // Called at a negedge with inputs applied; checks outputs, then advances one clock.
    task automatic cycle();
        logic        fire_resp, accept, any, w, e0, e1;
        logic [31:0] nres;
        #1;
        fire_resp = m_full && (m_owner ? bus_if.resp1_ready : bus_if.resp0_ready);
        accept    = !m_full || fire_resp;
        any       = bus_if.req0_valid || bus_if.req1_valid;
        w         = (bus_if.req0_valid && bus_if.req1_valid) ? !m_last : bus_if.req1_valid;
        e0        = accept && any && !w;
        e1        = accept && any && w;
        check("req0_ready",   bus_if.req0_ready,   e0);
        check("req1_ready",   bus_if.req1_ready,   e1);
        check("resp0_valid",  bus_if.resp0_valid,  m_full && !m_owner);
        check("resp1_valid",  bus_if.resp1_valid,  m_full && m_owner);
        check("resp0_result", bus_if.resp0_result, m_res);
        check("resp1_result", bus_if.resp1_result, m_res);
        check("busy",         bus_if.busy,         m_full);
        acc0 = e0;
        acc1 = e1;
        nres = w ? ref_shift(bus_if.req1_A, bus_if.req1_B, bus_if.req1_op)
                 : ref_shift(bus_if.req0_A, bus_if.req0_B, bus_if.req0_op);
        @(posedge clk);
        if (e0 || e1) begin
            m_full = 1'b1; m_owner = w; m_last = w; m_res = nres;
        end else if (fire_resp) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic        pend0, pend1;
        model_reset();
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b1, 32'h5, 32'h1, 2'b00);
        bus_if.resp0_ready = 1'b0;
        bus_if.resp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req1_ready", bus_if.req1_ready, 1'b0);
        check("rst_busy",       bus_if.busy,       1'b0);
        check("rst_result",     bus_if.resp0_result, 32'h0);
        rst = 1'b0;
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        cycle();

        // Single sra from requester 0
        set_req(0, 1'b1, 32'h8000_0000, 32'd4, 2'b11);
        cycle();
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        bus_if.resp0_ready = 1'b1;
        #1;
        check("sra_result",  bus_if.resp0_result, 32'hF800_0000);
        check("sra_r1valid", bus_if.resp1_valid,  1'b0);
        cycle();
        cycle();

        // Reset while a result is buffered
        set_req(0, 1'b1, 32'h1, 32'h1, 2'b00);
        bus_if.resp0_ready = 1'b0;
        cycle();
        set_req(0, 1'b1, 32'h3, 32'h2, 2'b00);
        set_req(1, 1'b1, 32'h3, 32'h3, 2'b00);
        #1;
        check("pre_rst_resp0_valid", bus_if.resp0_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_resp0_valid", bus_if.resp0_valid,  1'b0);
        check("mid_rst_req0_ready",  bus_if.req0_ready,   1'b0);
        check("mid_rst_req1_ready",  bus_if.req1_ready,   1'b0);
        check("mid_rst_result",      bus_if.resp0_result, 32'h0);
        check("mid_rst_busy",        bus_if.busy,         1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_grant0", bus_if.req0_ready, 1'b1);
        cycle();
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        bus_if.resp0_ready = 1'b1;
        cycle();

        // Shift amount truncation on requester 1
        bus_if.resp1_ready = 1'b1;
        set_req(1, 1'b1, 32'h1, 32'd33, 2'b00);
        cycle();
        set_req(1, 1'b1, 32'hF000_0000, 32'h20, 2'b10);
        #1;
        check("trunc_sll", bus_if.resp1_result, 32'h2);
        cycle();
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        #1;
        check("trunc_srl", bus_if.resp1_result, 32'hF000_0000);
        cycle();

        // Contention: alternate grants, one accept per cycle
        set_req(0, 1'b1, 32'h100, 32'd4, 2'b10);
        set_req(1, 1'b1, 32'h1,   32'd8, 2'b00);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("cont_result", bus_if.resp0_valid ? bus_if.resp0_result : bus_if.resp1_result,
                  bus_if.resp0_valid ? 32'h10 : 32'h100);
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        cycle();

        // Backpressure on requester 0 while requester 1 waits
        set_req(0, 1'b1, 32'h100, 32'd4, 2'b10);
        bus_if.resp0_ready = 1'b0;
        cycle();
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b1, 32'h1, 32'd8, 2'b00);
        repeat (3) begin
            cycle();
            check("bp_hold_result", bus_if.resp0_result, 32'h10);
        end
        bus_if.resp0_ready = 1'b1;
        #1;
        check("bp_release_req1_ready", bus_if.req1_ready, 1'b1);
        cycle();
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        #1;
        check("bp_resp1_valid", bus_if.resp1_valid, 1'b1);
        cycle();

        // Reserved op still handshakes and yields zero
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd3, 2'b01);
        cycle();
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        #1;
        check("rsvd_result", bus_if.resp0_result, 32'h0);
        check("rsvd_valid",  bus_if.resp0_valid,  1'b1);
        cycle();

        // Randomized traffic; pending requests keep their payload until accepted
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0) begin
                set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
                pend0 = bus_if.req0_valid;
            end
            if (!pend1) begin
                set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
                pend1 = bus_if.req1_valid;
            end
            bus_if.resp0_ready = ($urandom_range(0, 3) != 0);
            bus_if.resp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc0) pend0 = 1'b0;
            if (acc1) pend1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
